// File: rtl/addr_pkg.sv
// Shared types and helpers for the digit-serial adder.
package addr_pkg;

    // FSM states of the digit-serial adder
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addr_state_e;

    // Digit counter width: enough bits to hold NDIG-1, never less than one bit
    function automatic int cnt_width(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/addr_digit_cell.sv
// Combinational DIGIT-bit ripple adder with carry-in and carry-out.
module addr_digit_cell #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    // Ripple the carry LSB to MSB through the digit
    always_comb begin
        logic c;
        c = cin;
        s = '0;
        for (int i = 0; i < DIGIT; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/addr_digit_serial.sv
// Digit-serial unsigned adder: sum = a + b + cin, DIGIT bits per cycle.
// Optional duplicate digit adder with mismatch flag: ADDR_DIGIT_SERIAL_DMR_CHECK_EN.
//
// state | meaning
// IDLE  | ready for operands, in_ready high
// RUN   | one digit added per cycle, LSB digit first
// DONE  | result held on sum until out_ready
module addr_digit_serial
    import addr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             err
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("addr_digit_serial: WIDTH must be a positive multiple of DIGIT");
    end

    addr_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [DIGIT-1:0]       dig_s;
    logic                   dig_cout;
    logic [WIDTH+DIGIT-1:0] res_ext;

    addr_digit_cell #(.DIGIT(DIGIT)) u_cell (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .s    (dig_s),
        .cout (dig_cout)
    );

    // New digit enters at the top; the register holds the full result after NDIG shifts
    assign res_ext = {dig_s, res_q};

`ifdef ADDR_DIGIT_SERIAL_DMR_CHECK_EN
    logic [DIGIT-1:0] chk_s;
    logic             chk_cout;
    logic             mismatch;
    logic             err_q, err_d;

    addr_digit_cell #(.DIGIT(DIGIT)) u_cell_chk (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .s    (chk_s),
        .cout (chk_cout)
    );

    // Any disagreement between the two digit adders in a RUN cycle is a fault
    assign mismatch = (chk_s != dig_s) || (chk_cout != dig_cout);
    assign err      = err_q;
`else
    assign err = 1'b0;
`endif

    // Next-state, datapath and registered handshake decode
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef ADDR_DIGIT_SERIAL_DMR_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
`ifdef ADDR_DIGIT_SERIAL_DMR_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_ext[WIDTH+DIGIT-1:DIGIT];
                carry_d = dig_cout;
`ifdef ADDR_DIGIT_SERIAL_DMR_CHECK_EN
                if (mismatch) begin
                    err_d = 1'b1;
                end
`endif
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ADDR_DIGIT_SERIAL_DMR_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef ADDR_DIGIT_SERIAL_DMR_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = {carry_q, res_q};

endmodule

// File: tb/tb_addr_digit_serial.sv
// Bench for addr_digit_serial: five instances, WIDTH=16, DIGIT = 1,2,4,8,16.
module tb_addr_digit_serial;

    localparam int NI = 5;
    localparam int MAIN = 2;   // DIGIT=4 instance used for directed cases

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [NI];
    logic        in_ready  [NI];
    logic        out_valid [NI];
    logic [16:0] sum_o     [NI];
    logic        err_o     [NI];
    logic [15:0] a_in, b_in;
    logic        cin_in;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        addr_digit_serial #(.WIDTH(16), .DIGIT(1 << gi)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .a         (a_in),
            .b         (b_in),
            .cin       (cin_in),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready),
            .sum       (sum_o[gi]),
            .err       (err_o[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_accept(input int idx, input logic [15:0] av, input logic [15:0] bv, input logic cv);
        int n = 0;
        while (!in_ready[idx] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", 32'(in_ready[idx]), 32'd1);
        a_in          = av;
        b_in          = bv;
        cin_in        = cv;
        in_valid[idx] = 1'b1;
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
    endtask

    task automatic wait_done(input int idx, output int lat);
        lat = 0;
        while (!out_valid[idx] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_seen", 32'(out_valid[idx]), 32'd1);
    endtask

    // Reference: plain 17-bit arithmetic, latency WIDTH/DIGIT cycles
    task automatic run_op(input int idx, input logic [15:0] av, input logic [15:0] bv, input logic cv,
                          input string tag);
        logic [16:0] exp_sum;
        int          lat;
        exp_sum = {1'b0, av} + {1'b0, bv} + 17'(cv);
        do_accept(idx, av, bv, cv);
        wait_done(idx, lat);
        check({tag, "_sum"}, 32'(sum_o[idx]), 32'(exp_sum));
        check({tag, "_lat"}, 32'(lat), 32'(16 / (1 << idx)));
        check({tag, "_err"}, 32'(err_o[idx]), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        logic seen;
        rst       = 1'b1;
        out_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
        cin_in    = 1'b0;
        for (int i = 0; i < NI; i++) in_valid[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++) begin
            check("rst_in_ready", 32'(in_ready[i]), 32'd1);
            check("rst_out_valid", 32'(out_valid[i]), 32'd0);
            check("rst_sum", 32'(sum_o[i]), 32'd0);
            check("rst_err", 32'(err_o[i]), 32'd0);
        end

        run_op(MAIN, 16'hFFFF, 16'h0001, 1'b0, "ffff_p1");
        run_op(MAIN, 16'h0000, 16'h0000, 1'b1, "cin_only");
        run_op(MAIN, 16'h1234, 16'h4321, 1'b0, "p1234");

        // Backpressure: result must hold and no new operands captured
        out_ready = 1'b0;
        do_accept(MAIN, 16'h1111, 16'h2222, 1'b0);
        wait_done(MAIN, lat);
        check("bp_lat", 32'(lat), 32'd4);
        a_in            = 16'hAAAA;
        b_in            = 16'h5555;
        in_valid[MAIN]  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid[MAIN]), 32'd1);
            check("bp_sum", 32'(sum_o[MAIN]), 32'h3333);
            check("bp_in_ready", 32'(in_ready[MAIN]), 32'd0);
        end
        in_valid[MAIN] = 1'b0;
        out_ready      = 1'b1;
        @(posedge clk); #1;
        check("bp_rel_in_ready", 32'(in_ready[MAIN]), 32'd1);
        check("bp_rel_out_valid", 32'(out_valid[MAIN]), 32'd0);

        // Reset during the second RUN cycle
        do_accept(MAIN, 16'h1234, 16'h1111, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready[MAIN]), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid[MAIN]), 32'd0);
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            seen = seen | out_valid[MAIN];
        end
        check("mid_rst_no_result", 32'(seen), 32'd0);
        run_op(MAIN, 16'h00FF, 16'h0001, 1'b0, "after_rst");

`ifdef ADDR_DIGIT_SERIAL_DMR_CHECK_EN
        // Fault in the duplicate cell for one RUN cycle
        do_accept(MAIN, 16'h0000, 16'h0000, 1'b0);
        force tb_addr_digit_serial.g_dut[2].u_dut.chk_cout = 1'b1;
        @(posedge clk); #1;
        release tb_addr_digit_serial.g_dut[2].u_dut.chk_cout;
        wait_done(MAIN, lat);
        check("dmr_err", 32'(err_o[MAIN]), 32'd1);
        check("dmr_sum", 32'(sum_o[MAIN]), 32'd0);
        @(posedge clk); #1;
        run_op(MAIN, 16'h0F0F, 16'h00F1, 1'b1, "dmr_clean");
`endif

        // Random sweep over every DIGIT
        for (int idx = 0; idx < NI; idx++) begin
            for (int n = 0; n < 1000; n++) begin
                run_op(idx, 16'($urandom), 16'($urandom), 1'($urandom), "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
